acc_control: RTL

//  Multicycle control FSM for the 16-bit accumulator CPU; sits directly upstream of the ALU subsystem.

---
 rtl/acc_control_pkg.sv | 98 +++++++++
 rtl/acc_control_decode.sv | 109 ++++++++++
 rtl/acc_control.sv | 113 +++++++++++
 3 files changed

// File: rtl/acc_control_pkg.sv
// Shared encodings for the accumulator CPU control path.
// Holds the opcode map, the control FSM state encoding, the datapath mux
// select encodings (SrcA, SrcB, ALUOp, IorD, PCSrc, ACCSrc) and the packed
// control word that the decoder hands back to the top.
package acc_control_pkg;

    localparam int OPC_WIDTH = 4;

    typedef enum logic [3:0] {
        OP_LOAD  = 4'h0,
        OP_STORE = 4'h1,
        OP_ADD   = 4'h2,
        OP_SUB   = 4'h3,
        OP_AND   = 4'h4,
        OP_OR    = 4'h5,
        OP_ADDI  = 4'h6,
        OP_BEQZ  = 4'h7,
        OP_JUMP  = 4'h8,
        OP_PUSH  = 4'h9,
        OP_POP   = 4'hA,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [4:0] {
        S_IDLE, S_FETCH, S_DECODE,
        S_MEM_RD, S_LD_WB, S_ALU_MEM, S_ACC_WB,
        S_ST_WR, S_ALU_IMM,
        S_BR_CALC, S_BR_WB, S_JMP,
        S_PSH_DEC, S_PSH_SP, S_PSH_WR,
        S_POP_RD, S_POP_WB,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        SRCA_PC  = 3'd0,
        SRCA_ACC = 3'd1,
        SRCA_SP  = 3'd2
    } srca_e;

    typedef enum logic [3:0] {
        SRCB_TWO = 4'd0,
        SRCB_SE  = 4'd1,
        SRCB_MDR = 4'd2,
        SRCB_ZE  = 4'd3,
        SRCB_SL1 = 4'd4
    } srcb_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_PASSA = 3'd5
    } aluop_e;

    typedef enum logic [1:0] {
        IORD_PC = 2'd0,
        IORD_ZE = 2'd1,
        IORD_SP = 2'd2
    } iord_e;

    typedef enum logic {
        PCSRC_ALU  = 1'b0,
        PCSRC_JUMP = 1'b1
    } pcsrc_e;

    typedef enum logic {
        ACCSRC_ALU = 1'b0,
        ACCSRC_MDR = 1'b1
    } accsrc_e;

    typedef struct packed {
        logic    pcWrite;
        pcsrc_e  pcSrc;
        logic    irWrite;
        logic    memRead;
        logic    memWrite;
        iord_e   iorD;
        logic    accWrite;
        accsrc_e accSrc;
        logic    spWrite;
        srca_e   srcA;
        srcb_e   srcB;
        aluop_e  aluOp;
        logic    halted;
    } ctrl_t;

    // ALU operation used by the memory-operand arithmetic group.
    function automatic aluop_e memAluOp(input opcode_e opc);
        case (opc)
            OP_SUB:  memAluOp = ALU_SUB;
            OP_AND:  memAluOp = ALU_AND;
            OP_OR:   memAluOp = ALU_OR;
            default: memAluOp = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/acc_control_decode.sv
// Combinational control-word decoder for the accumulator CPU.
// Ports:
//   state_i   current FSM state
//   opcode_i  IR opcode (only used to pick the ALU op in ALU_MEM)
//   zflag_i   branch condition captured in BR_CALC
//   ctrl_o    full control word; every field is 0 unless the state drives it
module acc_control_decode
    import acc_control_pkg::*;
(
    input  state_e  state_i,
    input  opcode_e opcode_i,
    input  logic    zflag_i,
    output ctrl_t   ctrl_o
);

    // Start from an all-zero word so IDLE, HALT and unused selects stay 0.
    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.memRead = 1'b1;
                ctrl_o.iorD    = IORD_PC;
                ctrl_o.irWrite = 1'b1;
                ctrl_o.srcA    = SRCA_PC;
                ctrl_o.srcB    = SRCB_TWO;
                ctrl_o.aluOp   = ALU_ADD;
            end
            // PC takes the PC+2 computed in FETCH; ACC is passed through so
            // the registered Zero reflects ACC==0 for a following BEQZ.
            S_DECODE: begin
                ctrl_o.pcWrite = 1'b1;
                ctrl_o.pcSrc   = PCSRC_ALU;
                ctrl_o.srcA    = SRCA_ACC;
                ctrl_o.aluOp   = ALU_PASSA;
            end
            S_MEM_RD: begin
                ctrl_o.memRead = 1'b1;
                ctrl_o.iorD    = IORD_ZE;
            end
            S_LD_WB: begin
                ctrl_o.accWrite = 1'b1;
                ctrl_o.accSrc   = ACCSRC_MDR;
            end
            S_ALU_MEM: begin
                ctrl_o.srcA  = SRCA_ACC;
                ctrl_o.srcB  = SRCB_MDR;
                ctrl_o.aluOp = memAluOp(opcode_i);
            end
            S_ACC_WB: begin
                ctrl_o.accWrite = 1'b1;
                ctrl_o.accSrc   = ACCSRC_ALU;
            end
            S_ST_WR: begin
                ctrl_o.memWrite = 1'b1;
                ctrl_o.iorD     = IORD_ZE;
            end
            S_ALU_IMM: begin
                ctrl_o.srcA  = SRCA_ACC;
                ctrl_o.srcB  = SRCB_SE;
                ctrl_o.aluOp = ALU_ADD;
            end
            S_BR_CALC: begin
                ctrl_o.srcA  = SRCA_PC;
                ctrl_o.srcB  = SRCB_SL1;
                ctrl_o.aluOp = ALU_ADD;
            end
            S_BR_WB: begin
                ctrl_o.pcWrite = zflag_i;
                ctrl_o.pcSrc   = PCSRC_ALU;
            end
            S_JMP: begin
                ctrl_o.pcWrite = 1'b1;
                ctrl_o.pcSrc   = PCSRC_JUMP;
            end
            S_PSH_DEC: begin
                ctrl_o.srcA  = SRCA_SP;
                ctrl_o.srcB  = SRCB_TWO;
                ctrl_o.aluOp = ALU_SUB;
            end
            S_PSH_SP: begin
                ctrl_o.spWrite = 1'b1;
            end
            S_PSH_WR: begin
                ctrl_o.memWrite = 1'b1;
                ctrl_o.iorD     = IORD_SP;
            end
            // Read at the old SP while the ALU forms SP+2 for POP_WB.
            S_POP_RD: begin
                ctrl_o.memRead = 1'b1;
                ctrl_o.iorD    = IORD_SP;
                ctrl_o.srcA    = SRCA_SP;
                ctrl_o.srcB    = SRCB_TWO;
                ctrl_o.aluOp   = ALU_ADD;
            end
            S_POP_WB: begin
                ctrl_o.spWrite  = 1'b1;
                ctrl_o.accWrite = 1'b1;
                ctrl_o.accSrc   = ACCSRC_MDR;
            end
            S_HALT: begin
                ctrl_o.halted = 1'b1;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/acc_control.sv
// Multicycle control FSM for the 16-bit accumulator CPU.
// Holds the state register, next-state logic and the BEQZ condition flag;
// the control word itself comes from acc_control_decode.
// Ports:
//   CLK, Reset (async, active-high)
//   Opcode  IR[15:12], Zero  registered ALU zero flag
//   PCWrite, PCSrc, IRWrite, MemRead, MemWrite, IorD, ACCWrite, ACCSrc,
//   SPWrite, SrcA, SrcB, ALUOp  datapath controls; Halted  high in HALT
module acc_control
    import acc_control_pkg::*;
#(
    parameter int OPC_W    = 4,
    parameter int ILL_HALT = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [OPC_W-1:0] Opcode,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       IorD,
    output logic             ACCWrite,
    output logic             ACCSrc,
    output logic             SPWrite,
    output logic [2:0]       SrcA,
    output logic [3:0]       SrcB,
    output logic [2:0]       ALUOp,
    output logic             Halted
);

    state_e  state_q, state_d;
    logic    zflag_q, zflag_d;
    opcode_e opc;
    ctrl_t   ctrl;

    assign opc = opcode_e'(Opcode);

    // State and branch flag; reset drops any in-flight instruction.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            zflag_q <= zflag_d;
        end
    end

    // Zero carries DECODE's ACC==0 result only during BR_CALC.
    always_comb begin
        zflag_d = zflag_q;
        if (state_q == S_BR_CALC) begin
            zflag_d = Zero;
        end
    end

    // Instruction sequencing; undefined opcodes halt or act as NOP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opc)
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_MEM_RD;
                    OP_STORE: state_d = S_ST_WR;
                    OP_ADDI:  state_d = S_ALU_IMM;
                    OP_BEQZ:  state_d = S_BR_CALC;
                    OP_JUMP:  state_d = S_JMP;
                    OP_PUSH:  state_d = S_PSH_DEC;
                    OP_POP:   state_d = S_POP_RD;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = (ILL_HALT != 0) ? S_HALT : S_FETCH;
                endcase
            end
            S_MEM_RD:  state_d = (opc == OP_LOAD) ? S_LD_WB : S_ALU_MEM;
            S_ALU_MEM, S_ALU_IMM: state_d = S_ACC_WB;
            S_BR_CALC: state_d = S_BR_WB;
            S_PSH_DEC: state_d = S_PSH_SP;
            S_PSH_SP:  state_d = S_PSH_WR;
            S_POP_RD:  state_d = S_POP_WB;
            S_LD_WB, S_ACC_WB, S_ST_WR, S_BR_WB, S_JMP, S_PSH_WR, S_POP_WB:
                state_d = S_FETCH;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_IDLE;
        endcase
    end

    acc_control_decode uDecode (
        .state_i  (state_q),
        .opcode_i (opc),
        .zflag_i  (zflag_q),
        .ctrl_o   (ctrl)
    );

    assign PCWrite  = ctrl.pcWrite;
    assign PCSrc    = ctrl.pcSrc;
    assign IRWrite  = ctrl.irWrite;
    assign MemRead  = ctrl.memRead;
    assign MemWrite = ctrl.memWrite;
    assign IorD     = ctrl.iorD;
    assign ACCWrite = ctrl.accWrite;
    assign ACCSrc   = ctrl.accSrc;
    assign SPWrite  = ctrl.spWrite;
    assign SrcA     = ctrl.srcA;
    assign SrcB     = ctrl.srcB;
    assign ALUOp    = ctrl.aluOp;
    assign Halted   = ctrl.halted;

endmodule
